// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage controller and the 8-bit ALU:
// mode encodings, controller state encoding and carry-update selection.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_INC = 3'b010;
  localparam logic [2:0] ALU_DEC = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;
  localparam logic [2:0] ALU_CMP = 3'b111;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StCapture = 2'd2
  } exec_state_e;

  // Modes whose carry/borrow is architecturally visible; logic ops leave C untouched.
  function automatic logic is_arith(input logic [2:0] mode);
    logic res;
    case (mode)
      ALU_ADD, ALU_SUB, ALU_INC, ALU_DEC, ALU_CMP: res = 1'b1;
      ALU_AND, ALU_OR, ALU_XOR:                    res = 1'b0;
      default:                                     res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/reg_file.sv
// General-purpose register file: one synchronous write port, two operand read
// ports and one debug read port, all reads combinational.
module reg_file #(
  parameter int unsigned N    = 8,
  parameter int unsigned NREG = 4,
  localparam int unsigned RW  = $clog2(NREG)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [RW-1:0] waddr_i,
  input  logic [N-1:0]  wdata_i,
  input  logic [RW-1:0] raddr_a_i,
  output logic [N-1:0]  rdata_a_o,
  input  logic [RW-1:0] raddr_b_i,
  output logic [N-1:0]  rdata_b_o,
  input  logic [RW-1:0] dbg_addr_i,
  output logic [N-1:0]  dbg_data_o
);

  logic [N-1:0] regs_q [NREG];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      regs_q <= '{default: '0};
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o  = regs_q[raddr_a_i];
  assign rdata_b_o  = regs_q[raddr_b_i];
  assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller: accepts decoded instructions, drives the ALU for one
// cycle, writes the result back and maintains the architectural Z/C flags.
module alu_exec_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned N    = 8,
  parameter int unsigned NREG = 4,
  localparam int unsigned RW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic          instr_ldi,
  input  logic [2:0]    instr_mode,
  input  logic [RW-1:0] instr_rd,
  input  logic [RW-1:0] instr_rs,
  input  logic [N-1:0]  instr_imm,
  output logic          alu_enable,
  output logic [2:0]    alu_mode,
  output logic [N-1:0]  alu_a,
  output logic [N-1:0]  alu_b,
  input  logic [N-1:0]  alu_out,
  input  logic          alu_carry,
  output logic          flag_zero,
  output logic          flag_carry,
  output logic          exec_done,
  input  logic [RW-1:0] dbg_addr,
  output logic [N-1:0]  dbg_data
);

  // Reset asserts asynchronously but is released on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_int_n = rst_sync_q[1];

  exec_state_e   state_q, state_d;
  logic [2:0]    mode_q, mode_d;
  logic [RW-1:0] rd_q, rd_d;
  logic [N-1:0]  a_q, a_d, b_q, b_d;
  logic          z_q, z_d, c_q, c_d;
  logic          ldi_done_q, ldi_done_d;

  logic          accept, capture;
  logic          rf_we;
  logic [RW-1:0] rf_waddr;
  logic [N-1:0]  rf_wdata, rf_a, rf_b;

  assign accept  = instr_valid & instr_ready;
  assign capture = (state_q == StCapture);

  // LDI writes on accept and ALU writeback happens in CAPTURE; never both at once.
  assign rf_we    = (accept & instr_ldi) | (capture & (mode_q != ALU_CMP));
  assign rf_waddr = capture ? rd_q : instr_rd;
  assign rf_wdata = capture ? alu_out : instr_imm;

  reg_file #(
    .N    (N),
    .NREG (NREG)
  ) u_reg_file (
    .clk_i      (clk),
    .rst_ni     (rst_int_n),
    .we_i       (rf_we),
    .waddr_i    (rf_waddr),
    .wdata_i    (rf_wdata),
    .raddr_a_i  (instr_rd),
    .rdata_a_o  (rf_a),
    .raddr_b_i  (instr_rs),
    .rdata_b_o  (rf_b),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q    <= StIdle;
      mode_q     <= '0;
      rd_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      z_q        <= 1'b0;
      c_q        <= 1'b0;
      ldi_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      rd_q       <= rd_d;
      a_q        <= a_d;
      b_q        <= b_d;
      z_q        <= z_d;
      c_q        <= c_d;
      ldi_done_q <= ldi_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (accept && !instr_ldi) state_d = StIssue;
      StIssue:   state_d = StCapture;
      StCapture: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    mode_d     = mode_q;
    rd_d       = rd_q;
    a_d        = a_q;
    b_d        = b_q;
    z_d        = z_q;
    c_d        = c_q;
    ldi_done_d = 1'b0;
    if (accept) begin
      if (instr_ldi) begin
        ldi_done_d = 1'b1;
      end else begin
        mode_d = instr_mode;
        rd_d   = instr_rd;
        a_d    = rf_a;
        b_d    = ((instr_mode == ALU_INC) || (instr_mode == ALU_DEC)) ? '0 : rf_b;
      end
    end
    if (capture) begin
      // CMP compares the latched operands directly; the ALU's own zero flag is unused.
      z_d = (mode_q == ALU_CMP) ? (a_q == b_q) : (alu_out == '0);
      if (is_arith(mode_q)) c_d = alu_carry;
    end
  end

  always_comb begin
    instr_ready = (state_q == StIdle);
    alu_enable  = (state_q == StIssue);
    exec_done   = ldi_done_q | capture;
  end

  assign alu_mode   = mode_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign flag_zero  = z_q;
  assign flag_carry = c_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a behavioural 8-bit ALU and a
// scoreboard of expected register/flag state per instruction.
module tb_alu_exec_ctrl;
  import alu_pkg::*;

  localparam int N = 8;
  localparam int NREG = 4;
  localparam int RW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic          instr_ldi = 1'b0;
  logic [2:0]    instr_mode = '0;
  logic [RW-1:0] instr_rd = '0;
  logic [RW-1:0] instr_rs = '0;
  logic [N-1:0]  instr_imm = '0;
  logic          alu_enable;
  logic [2:0]    alu_mode;
  logic [N-1:0]  alu_a, alu_b;
  logic [N-1:0]  alu_out = '0;
  logic          alu_carry = 1'b0;
  logic          flag_zero, flag_carry, exec_done;
  logic [RW-1:0] dbg_addr = '0;
  logic [N-1:0]  dbg_data;

  always #5 clk = ~clk;

  alu_exec_ctrl #(
    .N    (N),
    .NREG (NREG)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_ldi   (instr_ldi),
    .instr_mode  (instr_mode),
    .instr_rd    (instr_rd),
    .instr_rs    (instr_rs),
    .instr_imm   (instr_imm),
    .alu_enable  (alu_enable),
    .alu_mode    (alu_mode),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_out     (alu_out),
    .alu_carry   (alu_carry),
    .flag_zero   (flag_zero),
    .flag_carry  (flag_carry),
    .exec_done   (exec_done),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  // Behavioural ALU: registers result and carry/borrow on an enabled edge.
  always @(posedge clk) begin
    if (alu_enable) begin
      case (alu_mode)
        ALU_ADD: {alu_carry, alu_out} <= {1'b0, alu_a} + {1'b0, alu_b};
        ALU_SUB, ALU_CMP: begin
          alu_out   <= alu_a - alu_b;
          alu_carry <= (alu_a < alu_b);
        end
        ALU_INC: {alu_carry, alu_out} <= {1'b0, alu_a} + 9'd1;
        ALU_DEC: begin
          alu_out   <= alu_a - 8'd1;
          alu_carry <= (alu_a == 8'd0);
        end
        ALU_AND: begin alu_out <= alu_a & alu_b; alu_carry <= 1'b0; end
        ALU_OR:  begin alu_out <= alu_a | alu_b; alu_carry <= 1'b0; end
        default: begin alu_out <= alu_a ^ alu_b; alu_carry <= 1'b0; end
      endcase
    end
  end

  int         tests = 0;
  int         fails = 0;
  int         done_cnt = 0;
  int         en_cnt = 0;
  logic [2:0] en_mode = '0;
  logic [7:0] en_a = '0, en_b = '0;

  always @(negedge clk) begin
    if (exec_done) done_cnt <= done_cnt + 1;
    if (alu_enable) begin
      en_cnt  <= en_cnt + 1;
      en_mode <= alu_mode;
      en_a    <= alu_a;
      en_b    <= alu_b;
    end
  end

  typedef struct {
    logic [1:0] rd;
    logic [7:0] val;
    logic       z;
    logic       c;
    int         lat;
    logic [2:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       ldi;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mregs[NREG];
  logic       mz = 1'b0, mc = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic ldi, input logic [2:0] mode, input logic [1:0] rd,
                            input logic [1:0] rs, input logic [7:0] imm, output exp_t e);
    logic [7:0] a, b;
    logic [8:0] s;
    a = mregs[rd];
    b = mregs[rs];
    e.ldi = ldi;
    e.mode = mode;
    e.a = a;
    e.b = (mode == ALU_INC || mode == ALU_DEC) ? 8'h00 : b;
    if (ldi) begin
      mregs[rd] = imm;
      e.lat = 1;
    end else begin
      e.lat = 2;
      case (mode)
        ALU_ADD: begin s = {1'b0, a} + {1'b0, b}; mregs[rd] = s[7:0]; mc = s[8]; end
        ALU_SUB: begin mregs[rd] = a - b; mc = (a < b); end
        ALU_INC: begin mregs[rd] = a + 8'd1; mc = (a == 8'hFF); end
        ALU_DEC: begin mregs[rd] = a - 8'd1; mc = (a == 8'h00); end
        ALU_AND: mregs[rd] = a & b;
        ALU_OR:  mregs[rd] = a | b;
        ALU_XOR: mregs[rd] = a ^ b;
        default: mc = (a < b);
      endcase
      mz = (mode == ALU_CMP) ? (a == b) : (mregs[rd] == 8'h00);
    end
    e.rd = rd;
    e.val = mregs[rd];
    e.z = mz;
    e.c = mc;
  endtask

  task automatic drive(input logic ldi, input logic [2:0] mode, input logic [1:0] rd,
                       input logic [1:0] rs, input logic [7:0] imm);
    exp_t e;
    instr_valid = 1'b1;
    instr_ldi = ldi;
    instr_mode = mode;
    instr_rd = rd;
    instr_rs = rs;
    instr_imm = imm;
    model_step(ldi, mode, rd, rs, imm, e);
    sb.push_back(e);
  endtask

  task automatic check_state(input string tag, input exp_t e);
    dbg_addr = e.rd;
    #1;
    check({tag, "_reg"}, dbg_data, e.val);
    check({tag, "_z"}, flag_zero, e.z);
    check({tag, "_c"}, flag_carry, e.c);
  endtask

  task automatic send(input string tag, input logic ldi, input logic [2:0] mode,
                      input logic [1:0] rd, input logic [1:0] rs, input logic [7:0] imm);
    exp_t e;
    int n;
    int en0;
    n = 0;
    @(negedge clk);
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) check({tag, "_ready_timeout"}, instr_ready, 1);
    drive(ldi, mode, rd, rs, imm);
    en0 = en_cnt;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!exec_done && n < 10);
    e = sb.pop_front();
    check({tag, "_latency"}, n, e.lat);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, exec_done, 0);
    if (!e.ldi) begin
      check({tag, "_en_cycles"}, en_cnt - en0, 1);
      check({tag, "_alu_mode"}, en_mode, e.mode);
      check({tag, "_alu_a"}, en_a, e.a);
      check({tag, "_alu_b"}, en_b, e.b);
    end
    check_state(tag, e);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_ready"}, instr_ready, 1);
    check({tag, "_en"}, alu_enable, 0);
    check({tag, "_done"}, exec_done, 0);
    check({tag, "_z"}, flag_zero, 0);
    check({tag, "_c"}, flag_carry, 0);
    for (int i = 0; i < NREG; i++) begin
      dbg_addr = i[1:0];
      #1;
      check({tag, "_reg"}, dbg_data, 0);
    end
  endtask

  initial begin
    exp_t e;
    int d0;
    for (int i = 0; i < NREG; i++) mregs[i] = 8'h00;

    #23;
    check_cleared("reset");
    check("reset_alu_mode", alu_mode, 0);
    check("reset_alu_a", alu_a, 0);
    check("reset_alu_b", alu_b, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(negedge clk);

    send("ldi_r0", 1'b1, ALU_ADD, 2'd0, 2'd0, 8'h05);
    send("ldi_r1", 1'b1, ALU_ADD, 2'd1, 2'd0, 8'h03);
    send("add_5_3", 1'b0, ALU_ADD, 2'd0, 2'd1, 8'h00);
    dbg_addr = 2'd0;
    #1 check("add_5_3_const", {dbg_data, flag_zero, flag_carry}, {8'h08, 2'b00});

    send("ldi_r2", 1'b1, ALU_ADD, 2'd2, 2'd0, 8'hFF);
    send("ldi_r3", 1'b1, ALU_ADD, 2'd3, 2'd0, 8'h01);
    send("add_wrap", 1'b0, ALU_ADD, 2'd2, 2'd3, 8'h00);
    send("and_keep_c", 1'b0, ALU_AND, 2'd3, 2'd3, 8'h00);
    #1 check("and_keep_c_const", {dbg_data, flag_zero, flag_carry}, {8'h01, 2'b01});

    send("ldi_r0b", 1'b1, ALU_ADD, 2'd0, 2'd0, 8'h03);
    send("ldi_r1b", 1'b1, ALU_ADD, 2'd1, 2'd0, 8'h05);
    send("sub_borrow", 1'b0, ALU_SUB, 2'd0, 2'd1, 8'h00);
    send("cmp_eq", 1'b0, ALU_CMP, 2'd1, 2'd1, 8'h00);
    #1 check("cmp_eq_const", {dbg_data, flag_zero, flag_carry}, {8'h05, 2'b10});

    send("ldi_r0c", 1'b1, ALU_ADD, 2'd0, 2'd0, 8'hFF);
    send("inc_wrap", 1'b0, ALU_INC, 2'd0, 2'd1, 8'h00);
    send("dec_wrap", 1'b0, ALU_DEC, 2'd0, 2'd2, 8'h00);
    #1 check("dec_wrap_const", {dbg_data, flag_zero, flag_carry}, {8'hFF, 2'b01});

    send("ldi_r1c", 1'b1, ALU_ADD, 2'd1, 2'd0, 8'hA5);
    send("or_op", 1'b0, ALU_OR, 2'd1, 2'd3, 8'h00);
    send("xor_self", 1'b0, ALU_XOR, 2'd1, 2'd1, 8'h00);

    // Back-to-back: valid held high across ADD then LDI.
    @(negedge clk);
    d0 = done_cnt;
    drive(1'b0, ALU_ADD, 2'd0, 2'd3, 8'h00);
    @(posedge clk);
    #1 drive(1'b1, ALU_ADD, 2'd3, 2'd0, 8'h5A);
    @(negedge clk);
    check("b2b_ready_issue", instr_ready, 0);
    @(negedge clk);
    check("b2b_ready_capture", instr_ready, 0);
    check("b2b_done_add", exec_done, 1);
    @(negedge clk);
    check("b2b_ready_idle", instr_ready, 1);
    check("b2b_no_early_done", exec_done, 0);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    check("b2b_done_ldi", exec_done, 1);
    @(negedge clk);
    @(posedge clk);
    #1 check("b2b_done_count", done_cnt - d0, 2);
    e = sb.pop_front();
    check_state("b2b_add", e);
    e = sb.pop_front();
    check_state("b2b_ldi", e);

    // Reset during ISSUE aborts the instruction.
    send("ldi_r2b", 1'b1, ALU_ADD, 2'd2, 2'd0, 8'h77);
    @(negedge clk);
    drive(1'b0, ALU_ADD, 2'd2, 2'd2, 8'h00);
    void'(sb.pop_back());
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_en_before", alu_enable, 1);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check_cleared("rst_mid");
    repeat (3) @(negedge clk);
    #1 check("rst_mid_no_done", done_cnt - d0, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < NREG; i++) mregs[i] = 8'h00;
    mz = 1'b0;
    mc = 1'b0;
    repeat (4) @(negedge clk);
    send("post_rst_ldi", 1'b1, ALU_ADD, 2'd1, 2'd0, 8'h42);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
- Execute-stage controller that sits directly upstream of the 8-bit ALU and also consumes its results.
- Accepts decoded instructions over a valid/ready handshake and reads operands from an internal register file.
- Drives the ALU for exactly one enabled clock edge, then captures the ALU result and carry.
- Writes the result back to the register file and maintains the architectural Z/C flag register used by later branch logic.

Parameters:
- N, 8, datapath width; must match the ALU's N.
- NREG, 4, number of general-purpose registers; address width RW = $clog2(NREG).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  block can accept an instruction.
- instr_ldi  in  1  1 = load-immediate, 0 = ALU op.
- instr_mode  in  3  ALU mode (ADD=000 SUB=001 INC=010 DEC=011 AND=100 OR=101 XOR=110 CMP=111).
- instr_rd  in  RW  destination register, also operand A.
- instr_rs  in  RW  operand B register.
- instr_imm  in  N  immediate for LDI.
- alu_enable  out  1  ALU enable.
- alu_mode  out  3  ALU mode.
- alu_a  out  N  ALU operand A.
- alu_b  out  N  ALU operand B.
- alu_out  in  N  ALU registered result.
- alu_carry  in  1  ALU registered carry/borrow.
- flag_zero  out  1  architectural Z.
- flag_carry  out  1  architectural C.
- exec_done  out  1  one-cycle pulse on instruction retire.
- dbg_addr  in  RW  debug register select.
- dbg_data  out  N  combinational read of regs[dbg_addr].

Behaviour:
- Reset (async assert, released synchronously by the design):
  - state=IDLE; all regs=0; flag_zero=0; flag_carry=0; alu_enable=0; alu_mode=0; alu_a=0; alu_b=0; exec_done=0.
  - instr_ready=1 (ready is purely state==IDLE).
  - Reset mid-operation aborts the instruction: no writeback, no flag update, no done pulse.
- FSM states IDLE, ISSUE, CAPTURE.
- IDLE:
  - instr_ready=1.
  - On valid&ready with instr_ldi=1: regs[rd]<=imm on that edge; exec_done=1 the next cycle; flags unchanged; state stays IDLE.
  - On valid&ready with instr_ldi=0: latch mode/rd/rs, latch A=regs[rd] and B=regs[rs]; go to ISSUE.
  - For INC/DEC, B is latched as 0.
- ISSUE (1 cycle):
  - instr_ready=0; alu_enable=1; alu_mode/alu_a/alu_b = latched values.
  - The ALU registers its result on the closing edge. Go to CAPTURE.
- CAPTURE (1 cycle):
  - alu_enable=0; sample alu_out/alu_carry.
  - Non-CMP ops: regs[rd]<=alu_out.
  - CMP: no register write.
  - Z: for result ops Z<=(alu_out==0); for CMP Z<=(A==B), computed locally. The ALU's own zero flag is not used.
  - C: ADD/SUB/INC/DEC/CMP C<=alu_carry; AND/OR/XOR C unchanged.
  - exec_done=1 during this cycle. Go to IDLE.
- Latency: ALU op accepted at edge E0; alu_enable high between E0 and E1; writeback and flags at E2; exec_done high between E1 and E2. Next accept is possible at E3.
- alu_a/alu_b/alu_mode hold their last values outside ISSUE. The ALU ignores them while alu_enable=0.
- Arithmetic is modulo 2^N. Carry on SUB/DEC/CMP is the borrow as produced by the ALU.
- rd==rs is legal: both operands read the same register.
- dbg_data reflects writes from the edge after the write.
- instr_* inputs are ignored when ready=0 and are not required to be stable.

Decomposition:
- Shared package alu_pkg:
  - ALU mode constants ALU_ADD..ALU_CMP, shared with the ALU.
  - State encoding IDLE/ISSUE/CAPTURE.
  - Helper is_arith(mode) for carry-update selection.
- Sub-module reg_file: NREG x N, one synchronous write port, two combinational operand read ports plus one debug read port, async active-low reset to 0.

Test Plan:
- Reset, LDI R0=0x05, LDI R1=0x03, ADD rd=0 rs=1 -> alu_enable high exactly 1 cycle with mode=000, a=0x05, b=0x03; R0=0x08, Z=0, C=0; exec_done 2 cycles after accept.
- LDI R2=0xFF, LDI R3=0x01, ADD rd=2 rs=3 -> R2=0x00, Z=1, C=1. Then AND rd=3 rs=3 -> R3=0x01, Z=0, C stays 1.
- LDI R0=0x03, LDI R1=0x05, SUB rd=0 rs=1 -> R0=0xFE, C=1, Z=0. Then CMP R1,R1 (0x05) -> R1 unchanged, Z=1, C=0.
- INC on R0=0xFF -> R0=0x00, Z=1, C=1, alu_b=0. DEC on R0=0x00 -> R0=0xFF, C=1, Z=0.
- instr_valid held high with ADD then LDI queued -> ready low in ISSUE and CAPTURE; second instruction accepted on the first IDLE edge only; exactly one exec_done per instruction.
- rst_n pulled low during ISSUE -> alu_enable drops immediately, all regs=0, flags=0, ready=1, no exec_done; after release an LDI completes normally.
